// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer for the three-stage RV32I core.
// Reads are combinational; interrupts and mret redirect fetch in the same cycle.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] pc,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_red,
  input  logic        csr_write,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic        mie_meie_q, mie_meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        ext_hit, tmr_hit, trap, do_mret, do_write;
  logic [3:0]  trap_code;
  logic [31:0] trap_base, trap_target;
  logic [63:0] mcycle_inc, minstret_inc;

  // Interrupt arbitration uses only current state, so an MIE write cannot trap in its own cycle.
  always_comb begin
    ext_hit     = mie_meie_q & ext_irq;
    tmr_hit     = mie_mtie_q & timer_irq;
    trap        = inst_valid & mstatus_mie_q & (ext_hit | tmr_hit);
    trap_code   = ext_hit ? 4'd11 : 4'd7;
    do_mret     = inst_valid & is_mret & ~trap;
    do_write    = inst_valid & csr_write & ~trap & ~is_mret;
    trap_base   = mtvec_q & 32'hFFFF_FFFC;
    if (mtvec_q[0]) begin
      trap_target = trap_base + {26'd0, trap_code, 2'b00};
    end else begin
      trap_target = trap_base;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    if (csr_red) begin
      case (csr_addr)
        ADDR_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
        ADDR_MIE:       csr_rdata = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
        ADDR_MTVEC:     csr_rdata = mtvec_q;
        ADDR_MEPC:      csr_rdata = mepc_q;
        ADDR_MCAUSE:    csr_rdata = mcause_q;
        ADDR_MIP:       csr_rdata = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
        ADDR_MCYCLE:    csr_rdata = mcycle_q[31:0];
        ADDR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
        ADDR_MINSTRET:  csr_rdata = minstret_q[31:0];
        ADDR_MINSTRETH: csr_rdata = minstret_q[63:32];
        ADDR_MHARTID:   csr_rdata = HART_ID;
        default:        csr_rdata = 32'd0;
      endcase
    end else begin
      csr_rdata = 32'd0;
    end
  end

  // Next state: a trap squashes the instruction; mret outranks a stray CSR write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_inc     = mcycle_q + 64'd1;
    minstret_inc   = minstret_q + 64'd1;
    mcycle_d       = mcycle_inc;
    if (inst_valid & ~trap) begin
      minstret_d = minstret_inc;
    end else begin
      minstret_d = minstret_q;
    end

    if (trap) begin
      mepc_d         = pc & 32'hFFFF_FFFC;
      mcause_d       = {1'b1, 27'd0, trap_code};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (do_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (do_write) begin
      // A half-write replaces that half's increment; the other half still takes its carry.
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        ADDR_MIE: begin
          mie_mtie_d = csr_wdata[7];
          mie_meie_d = csr_wdata[11];
        end
        ADDR_MTVEC:     mtvec_d = csr_wdata & 32'hFFFF_FFFD;
        ADDR_MEPC:      mepc_d = csr_wdata & 32'hFFFF_FFFC;
        ADDR_MCAUSE:    mcause_d = csr_wdata;
        ADDR_MCYCLE:    mcycle_d[31:0] = csr_wdata;
        ADDR_MCYCLEH:   mcycle_d[63:32] = csr_wdata;
        ADDR_MINSTRET:  minstret_d[31:0] = csr_wdata;
        ADDR_MINSTRETH: minstret_d[63:32] = csr_wdata;
        default:        mcause_d = mcause_q;
      endcase
    end else begin
      mcause_d = mcause_q;
    end
  end

  always_comb begin
    epc_taken   = rst_n & (trap | do_mret);
    redirect_pc = 32'd0;
    if (!epc_taken) begin
      redirect_pc = 32'd0;
    end else if (trap) begin
      redirect_pc = trap_target;
    end else begin
      redirect_pc = mepc_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & 32'hFFFF_FFFD;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mcycle_q       <= 64'd0;
      minstret_q     <= 64'd0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scenario bench for csr_unit: expected CSR reads are queued as stimulus is driven,
// then drained and compared; redirect outputs are checked in the cycle they appear.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_red;
  logic        csr_write;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  csr_unit #(
    .MTVEC_RESET(32'h0000_0203),
    .HART_ID    (32'h0000_0005)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .pc         (pc),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_red    (csr_red),
    .csr_write  (csr_write),
    .is_mret    (is_mret),
    .timer_irq  (timer_irq),
    .ext_irq    (ext_irq),
    .csr_rdata  (csr_rdata),
    .epc_taken  (epc_taken),
    .redirect_pc(redirect_pc)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    csr_write  = 1'b0;
    is_mret    = 1'b0;
    csr_red    = 1'b0;
    csr_addr   = 12'h000;
    csr_wdata  = 32'd0;
    pc         = 32'd0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    inst_valid = 1'b1;
    csr_write  = 1'b1;
    csr_addr   = a;
    csr_wdata  = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_red  = 1'b1;
    csr_addr = a;
    #1;
    v        = csr_rdata;
    csr_red  = 1'b0;
  endtask

  task automatic want(input logic [11:0] a, input logic [31:0] v);
    exp_t e;
    e.addr = a;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    rst_n = 1'b0;
    step();
    inst_valid = 1'b1;
    is_mret    = 1'b1;
    step();
    #1;
    n_cmp++;
    if (epc_taken !== 1'b0 || redirect_pc !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got taken=%b pc=%h want 0/00000000", epc_taken, redirect_pc);
    end
    idle();
    rst_n = 1'b1;
    want(12'h300, 32'h0000_1800); want(12'h305, 32'h0000_0201);
    want(12'h304, 32'h0);         want(12'h341, 32'h0);
    want(12'h342, 32'h0);         want(12'hF14, 32'h5);
    want(12'h344, 32'h0);         want(12'hB02, 32'h0);
    want(12'hB00, 32'h0);         want(12'hB80, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL reset_read[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_regmap();
    exp_t e;
    logic [31:0] obs;
    wr(12'h304, 32'hFFFF_FFFF); wr(12'h305, 32'hFFFF_FFFF);
    wr(12'h341, 32'h0000_1237); wr(12'h342, 32'hDEAD_BEEF);
    wr(12'hF14, 32'h0000_0099); wr(12'h344, 32'h0000_FFFF);
    wr(12'h7C0, 32'h0000_ABCD); wr(12'h300, 32'hFFFF_FFF7);
    want(12'h304, 32'h0000_0880); want(12'h305, 32'hFFFF_FFFD);
    want(12'h341, 32'h0000_1234); want(12'h342, 32'hDEAD_BEEF);
    want(12'hF14, 32'h0000_0005); want(12'h344, 32'h0);
    want(12'h7C0, 32'h0);         want(12'h300, 32'h0000_1880);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL regmap_read[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
    csr_red = 1'b0; csr_addr = 12'h300; #1;
    n_cmp++;
    if (csr_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL rdata_without_red: got %h want 00000000", csr_rdata);
    end
    timer_irq = 1'b1;
    rd(12'h344, obs);
    n_cmp++;
    if (obs !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL mip_timer: got %h want 00000080", obs);
    end
    ext_irq = 1'b1;
    rd(12'h344, obs);
    n_cmp++;
    if (obs !== 32'h0000_0880) begin
      n_err++;
      $display("FAIL mip_both: got %h want 00000880", obs);
    end
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
  endtask

  task automatic test_trap_timer();
    exp_t e;
    logic [31:0] obs;
    wr(12'h305, 32'h0000_0101); wr(12'h304, 32'h0000_0080); wr(12'h300, 32'h0000_0008);
    timer_irq = 1'b1; inst_valid = 1'b1; pc = 32'h0000_0040;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_011C) begin
      n_err++;
      $display("FAIL trap_timer_redirect: got taken=%b pc=%h want 1/0000011c", epc_taken, redirect_pc);
    end
    step();
    idle();
    want(12'h341, 32'h0000_0040); want(12'h342, 32'h8000_0007); want(12'h300, 32'h0000_1880);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL trap_timer_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
    inst_valid = 1'b1;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b0) begin
      n_err++;
      $display("FAIL trap_masked_after_entry: got taken=%b want 0", epc_taken);
    end
    step();
    idle();
    timer_irq = 1'b0;
  endtask

  task automatic test_mret();
    exp_t e;
    logic [31:0] obs;
    inst_valid = 1'b1; is_mret = 1'b1;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL mret_redirect: got taken=%b pc=%h want 1/00000040", epc_taken, redirect_pc);
    end
    step();
    idle();
    want(12'h300, 32'h0000_1888);
    inst_valid = 1'b1; is_mret = 1'b1; csr_write = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h0000_1234;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL mret_with_write_redirect: got taken=%b pc=%h want 1/00000040", epc_taken, redirect_pc);
    end
    step();
    idle();
    want(12'h342, 32'h8000_0007); want(12'h300, 32'h0000_1888);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL mret_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_trap_priority();
    exp_t e;
    logic [31:0] obs;
    wr(12'h304, 32'h0000_0880);
    ext_irq = 1'b1; timer_irq = 1'b1;
    inst_valid = 1'b1; pc = 32'h0000_0088;
    csr_write = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_012C) begin
      n_err++;
      $display("FAIL trap_ext_redirect: got taken=%b pc=%h want 1/0000012c", epc_taken, redirect_pc);
    end
    step();
    idle();
    ext_irq = 1'b0; timer_irq = 1'b0;
    want(12'h342, 32'h8000_000B); want(12'h305, 32'h0000_0101);
    want(12'h341, 32'h0000_0088); want(12'h300, 32'h0000_1880);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL trap_priority_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_mie_write_timing();
    exp_t e;
    logic [31:0] obs;
    timer_irq = 1'b1;
    inst_valid = 1'b1; csr_write = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h0000_0008;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b0) begin
      n_err++;
      $display("FAIL mie_write_same_cycle: got taken=%b want 0", epc_taken);
    end
    step();
    idle();
    inst_valid = 1'b1; pc = 32'h0000_0106;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_011C) begin
      n_err++;
      $display("FAIL mie_write_next_cycle: got taken=%b pc=%h want 1/0000011c", epc_taken, redirect_pc);
    end
    step();
    idle();
    timer_irq = 1'b0;
    want(12'h341, 32'h0000_0104); want(12'h342, 32'h8000_0007); want(12'h300, 32'h0000_1880);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL mie_timing_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_direct_mode();
    exp_t e;
    logic [31:0] obs;
    wr(12'h305, 32'h0000_0200);
    inst_valid = 1'b1; is_mret = 1'b1;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_0104) begin
      n_err++;
      $display("FAIL direct_mret_redirect: got taken=%b pc=%h want 1/00000104", epc_taken, redirect_pc);
    end
    step();
    idle();
    ext_irq = 1'b1; inst_valid = 1'b1; pc = 32'h0000_0300;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b1 || redirect_pc !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL direct_trap_redirect: got taken=%b pc=%h want 1/00000200", epc_taken, redirect_pc);
    end
    step();
    idle();
    ext_irq = 1'b0;
    want(12'h342, 32'h8000_000B); want(12'h341, 32'h0000_0300);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL direct_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_counters();
    exp_t e;
    logic [31:0] obs;
    for (int phase = 0; phase < 7; phase++) begin
      case (phase)
        0: begin
          wr(12'hB00, 32'hFFFF_FFFE); wr(12'hB80, 32'h0);
          want(12'hB00, 32'hFFFF_FFFF); want(12'hB80, 32'h0);
        end
        1: begin
          step();
          want(12'hB00, 32'h0); want(12'hB80, 32'h1);
        end
        2: begin
          wr(12'hB00, 32'h0000_1234);
          want(12'hB00, 32'h0000_1234);
        end
        3: begin
          step();
          want(12'hB00, 32'h0000_1235);
        end
        4: begin
          wr(12'hB80, 32'hFFFF_FFFF); wr(12'hB00, 32'hFFFF_FFFF);
          want(12'hB80, 32'hFFFF_FFFF); want(12'hB00, 32'hFFFF_FFFF);
        end
        5: begin
          step();
          want(12'hB00, 32'h0); want(12'hB80, 32'h0);
        end
        default: begin
          wr(12'hB02, 32'hFFFF_FFFF); wr(12'hB82, 32'h0000_0007);
          want(12'hB02, 32'h0); want(12'hB82, 32'h0000_0007);
        end
      endcase
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        rd(e.addr, obs);
        n_cmp++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL counter_p%0d[%h]: got %h want %h", phase, e.addr, obs, e.val);
        end
      end
    end
    inst_valid = 1'b1;
    step();
    idle();
    rd(12'hB02, obs);
    n_cmp++;
    if (obs !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL minstret_after_inst: got %h want 00000001", obs);
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic [31:0] obs;
    wr(12'hB00, 32'h0000_0100);
    inst_valid = 1'b0; csr_write = 1'b1; csr_addr = 12'hB02; csr_wdata = 32'h0000_DEAD; is_mret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (epc_taken !== 1'b0) begin
        n_err++;
        $display("FAIL bubble_no_redirect[%0d]: got taken=%b want 0", i, epc_taken);
      end
      step();
    end
    idle();
    want(12'hB00, 32'h0000_0105); want(12'hB02, 32'h0000_0002); want(12'hB80, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL bubble_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_trap();
    exp_t e;
    logic [31:0] obs;
    wr(12'h300, 32'h0000_0008);
    timer_irq = 1'b1; inst_valid = 1'b1; pc = 32'h0000_0500; rst_n = 1'b0;
    #1;
    n_cmp++;
    if (epc_taken !== 1'b0 || redirect_pc !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_trap_outputs: got taken=%b pc=%h want 0/00000000", epc_taken, redirect_pc);
    end
    step();
    idle();
    timer_irq = 1'b0;
    rst_n = 1'b1;
    want(12'h300, 32'h0000_1800); want(12'h341, 32'h0);
    want(12'h342, 32'h0);         want(12'h305, 32'h0000_0201);
    want(12'h304, 32'h0);         want(12'hB02, 32'h0);
    want(12'hB80, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(e.addr, obs);
      n_cmp++;
      if (obs !== e.val) begin
        n_err++;
        $display("FAIL reset_mid_trap_state[%h]: got %h want %h", e.addr, obs, e.val);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
    idle();
    test_reset();
    test_regmap();
    test_trap_timer();
    test_mret();
    test_trap_priority();
    test_mie_write_timing();
    test_direct_mode();
    test_counters();
    test_bubbles();
    test_reset_mid_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
